// File: rtl/ibex_branch_predict_pkg.sv
// ============================================================================
// Module      : ibex_branch_predict_pkg
// Description : Opcode and funct3 constants for the static branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ibex_branch_predict_pkg;

  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  localparam logic [1:0] C_QUADRANT1 = 2'b01;

  localparam logic [2:0] C_F3_J    = 3'b101;
  localparam logic [2:0] C_F3_JAL  = 3'b001;
  localparam logic [2:0] C_F3_BEQZ = 3'b110;
  localparam logic [2:0] C_F3_BNEZ = 3'b111;

endpackage

`default_nettype wire

// File: rtl/ibex_branch_predict_static.sv
// ============================================================================
// Module      : ibex_branch_predict_static
// Description : Combinational static predictor: jumps taken, backward branches
//               taken. Compressed decode is enabled by BRANCH_PREDICT_RVC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_branch_predict_static
  import ibex_branch_predict_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        fetch_valid_i,
  output logic        predict_branch_taken_o,
  output logic [31:0] predict_branch_pc_o
);

  logic [31:0] w_instr;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_cj;
  logic [31:0] w_imm_cb;
  logic [31:0] w_imm;
  logic        w_instr_j;
  logic        w_instr_b;
  logic        w_instr_cj;
  logic        w_instr_cb;
  logic        w_b_taken;

  // Clock and reset exist only for interface uniformity; the predictor is stateless.
  logic        w_unused_clk_rst;
  assign w_unused_clk_rst = clk_i ^ rst_ni;

  assign w_instr = fetch_rdata_i;

  assign w_instr_j = (w_instr[6:0] == OPC_JAL);
  assign w_instr_b = (w_instr[6:0] == OPC_BRANCH);

  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                    w_instr[30:21], 1'b0};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                    w_instr[11:8], 1'b0};

`ifdef BRANCH_PREDICT_RVC_EN
  assign w_instr_cj = (w_instr[1:0] == C_QUADRANT1) &&
                      ((w_instr[15:13] == C_F3_J) || (w_instr[15:13] == C_F3_JAL));
  assign w_instr_cb = (w_instr[1:0] == C_QUADRANT1) &&
                      ((w_instr[15:13] == C_F3_BEQZ) || (w_instr[15:13] == C_F3_BNEZ));

  assign w_imm_cj = {{20{w_instr[12]}}, w_instr[12], w_instr[8], w_instr[10:9],
                     w_instr[6], w_instr[7], w_instr[2], w_instr[11],
                     w_instr[5:3], 1'b0};
  assign w_imm_cb = {{23{w_instr[12]}}, w_instr[12], w_instr[6:5], w_instr[2],
                     w_instr[11:10], w_instr[4:3], 1'b0};
`else
  assign w_instr_cj = 1'b0;
  assign w_instr_cb = 1'b0;
  assign w_imm_cj   = 32'h0;
  assign w_imm_cb   = 32'h0;
`endif

  always_comb begin
    w_imm = 32'h0;
    if (w_instr_j) begin
      w_imm = w_imm_j;
    end else if (w_instr_b) begin
      w_imm = w_imm_b;
    end else if (w_instr_cj) begin
      w_imm = w_imm_cj;
    end else if (w_instr_cb) begin
      w_imm = w_imm_cb;
    end
  end

  // Backward conditional branches are predicted taken (loop heuristic).
  assign w_b_taken = (w_instr_b & w_imm_b[31]) | (w_instr_cb & w_imm_cb[31]);

  assign predict_branch_taken_o = fetch_valid_i & (w_instr_j | w_instr_cj | w_b_taken);
  assign predict_branch_pc_o    = fetch_pc_i + w_imm;

endmodule

`default_nettype wire

// File: tb/tb_ibex_branch_predict_static.sv
// ============================================================================
// Module      : tb_ibex_branch_predict_static
// Description : Directed and randomized checks of ibex_branch_predict_static.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibex_branch_predict_static;

  logic        clk;
  logic        rst_n;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic        valid;
  logic        taken;
  logic [31:0] target;

  int n_checks = 0;
  int n_errors = 0;

`ifdef BRANCH_PREDICT_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  ibex_branch_predict_static dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .fetch_rdata_i          (rdata),
    .fetch_pc_i             (pc),
    .fetch_valid_i          (valid),
    .predict_branch_taken_o (taken),
    .predict_branch_pc_o    (target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Offset from a table giving, for each immediate bit, its source bit in the word.
  function automatic int offset_of(input logic [31:0] ins, input int fmt);
    int src[$];
    longint v;
    int n;
    case (fmt)
      0: src = '{-1, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 20,
                 12, 13, 14, 15, 16, 17, 18, 19, 31};
      1: src = '{-1, 8, 9, 10, 11, 25, 26, 27, 28, 29, 30, 7, 31};
      2: src = '{-1, 3, 4, 5, 11, 2, 7, 6, 9, 10, 8, 12};
      default: src = '{-1, 3, 4, 10, 11, 2, 5, 6, 12};
    endcase
    n = src.size();
    v = 0;
    for (int k = 1; k < n - 1; k++)
      if (ins[src[k]]) v += (longint'(1) << k);
    if (ins[src[n-1]]) v -= (longint'(1) << (n - 1));
    return int'(v);
  endfunction

  task automatic model(input logic [31:0] ins, input logic [31:0] p, input logic v,
                       output logic exp_taken, output logic [31:0] exp_pc);
    bit is_j, is_b, is_cj, is_cb;
    int off;
    is_j  = (ins[6:0] == 7'h6F);
    is_b  = (ins[6:0] == 7'h63);
    is_cj = RVC && ins[1:0] == 2'b01 && (ins[15:13] == 3'd5 || ins[15:13] == 3'd1);
    is_cb = RVC && ins[1:0] == 2'b01 && (ins[15:13] == 3'd6 || ins[15:13] == 3'd7);
    if (is_j)       off = offset_of(ins, 0);
    else if (is_b)  off = offset_of(ins, 1);
    else if (is_cj) off = offset_of(ins, 2);
    else if (is_cb) off = offset_of(ins, 3);
    else            off = 0;
    exp_taken = v && (is_j || is_cj || ((is_b || is_cb) && off < 0));
    exp_pc    = p + 32'(off);
  endtask

  task automatic apply(input logic [31:0] ins, input logic [31:0] p, input logic v,
                       input string tag);
    logic        et;
    logic [31:0] ep;
    @(negedge clk);
    rdata = ins;
    pc    = p;
    valid = v;
    #1;
    model(ins, p, v, et, ep);
    check({tag, ".taken"}, {31'h0, taken}, {31'h0, et});
    check({tag, ".pc"}, target, ep);
  endtask

  initial begin
    logic [31:0] ins;
    logic [31:0] r;
    rst_n = 1'b0;
    rdata = 32'h0080006F;
    pc    = 32'h100;
    valid = 1'b1;
    #1;
    // Outputs follow inputs even while reset is asserted.
    check("reset.taken", {31'h0, taken}, 32'h1);
    check("reset.pc", target, 32'h108);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    apply(32'h0080006F, 32'h100, 1'b1, "jal_p8");
    check("jal_p8.const", target, 32'h108);
    apply(32'hFE000EE3, 32'h200, 1'b1, "beq_m4");
    check("beq_m4.const", {target[31:1], taken}, 32'h1FD);
    apply(32'h00000463, 32'h200, 1'b1, "beq_p8");
    check("beq_p8.const", {target[31:1], taken}, 32'h208);
    apply(32'h0000BFFD, 32'h300, 1'b1, "cj_m2");
    check("cj_m2.const", {31'h0, taken}, {31'h0, RVC});
    apply(32'h0000DC7D, 32'h400, 1'b1, "cbeqz_m2");
    check("cbeqz_m2.const", {31'h0, taken}, {31'h0, RVC});
    apply(32'h0000DC7D, 32'h400, 1'b0, "cbeqz_inv");
    check("cbeqz_inv.const", {31'h0, taken}, 32'h0);
    apply(32'h00000013, 32'h1234, 1'b1, "addi");
    check("addi.const", {31'h0, taken}, 32'h0);
    apply(32'h0080006F, 32'hFFFFFFFC, 1'b1, "jal_wrap");
    check("jal_wrap.const", target, 32'h00000004);
    apply(32'hFFFF0067, 32'h500, 1'b1, "jalr");
    apply(32'hABCD8082, 32'h600, 1'b1, "cjr");
    apply(32'hFFFFDC7D, 32'h400, 1'b1, "cb_upper");

    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      case ($urandom_range(0, 5))
        0: ins = {r[31:7], 7'h6F};
        1: ins = {r[31:7], 7'h63};
        2: ins = {r[31:16], 3'($urandom_range(0, 7)), r[12:2], 2'b01};
        3: ins = {r[31:7], 7'h67};
        4: ins = {r[31:16], 3'b100, r[12:2], 2'b10};
        default: ins = r;
      endcase
      apply(ins, $urandom, 1'($urandom_range(0, 3) != 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ibex_branch_predict_static.md
Name: ibex_branch_predict_static

Overview:
- Static branch predictor in the instruction-fetch stage.
- Decodes the fetched instruction word and predicts:
  - jumps (JAL, C.J, C.JAL) are always taken;
  - conditional branches are taken only when their offset is negative (backward).
- Outputs a taken flag and the predicted target (fetch PC + immediate) so fetch can redirect in the same cycle.

Parameters:
- None. Datapath fixed at 32 bits (RV32).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, synchronous, active-low.
- fetch_rdata_i  input  32  fetched instruction word. A compressed instruction sits in bits [15:0].
- fetch_pc_i  input  32  PC of the fetched instruction.
- fetch_valid_i  input  1  fetch_rdata_i/fetch_pc_i hold a valid instruction.
- predict_branch_taken_o  output  1  prediction: taken.
- predict_branch_pc_o  output  32  predicted target address.

Behaviour:
- Fully combinational, zero latency. Outputs settle in the same cycle as the inputs and need no clock edge.
- clk_i/rst_ni are present for interface uniformity only. No state, so reset has no effect on outputs; outputs follow the inputs during and after reset.
- Classification, with instr = fetch_rdata_i:
  - instr_j: instr[6:0]==7'h6F (JAL).
  - instr_b: instr[6:0]==7'h63 (BRANCH).
  - instr_cj: instr[1:0]==2'b01 and instr[15:13] in {3'b101 (C.J), 3'b001 (C.JAL)}.
  - instr_cb: instr[1:0]==2'b01 and instr[15:13] in {3'b110 (C.BEQZ), 3'b111 (C.BNEZ)}.
- Immediates, all sign-extended to 32 bits with bit0 = 0:
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - CJ: {instr[12], instr[8], instr[10:9], instr[6], instr[7], instr[2], instr[11], instr[5:3], 0}.
  - CB: {instr[12], instr[6:5], instr[2], instr[11:10], instr[4:3], 0}.
- Immediate select priority: J, then B, then CJ, then CB. Any other instruction selects immediate 0.
- predict_branch_pc_o = fetch_pc_i + selected immediate, modulo 2^32 (wraps silently).
  - Computed regardless of fetch_valid_i or the prediction; only meaningful when taken.
- b_taken = (instr_b & imm_b[31]) | (instr_cb & imm_cb[31]).
- predict_branch_taken_o = fetch_valid_i & (instr_j | instr_cj | b_taken).
- Never predicts JALR, C.JR, C.JALR, or any non-control-flow instruction.
- fetch_valid_i low forces taken = 0.
- Upper half of fetch_rdata_i is ignored for compressed instructions.

Optional Feature:
- Macro: BRANCH_PREDICT_RVC_EN.
- Defined: compressed decode (instr_cj, instr_cb, CJ/CB immediates) is included as described above.
- Undefined: instr_cj and instr_cb are tied to 0. Only JAL and 32-bit BRANCH are predicted, and compressed words always give taken = 0.

Decomposition:
- Package ibex_branch_predict_pkg holds:
  - opcode constants OPC_JAL=7'h6F and OPC_BRANCH=7'h63;
  - compressed quadrant value 2'b01;
  - funct3 constants for C.J, C.JAL, C.BEQZ, C.BNEZ.
- No sub-module needed; immediate extraction is inline combinational logic in one module.

Test Plan:
- JAL +8: rdata=0x0080006F, pc=0x100, valid=1 -> taken=1, target=0x108.
- BEQ -4: rdata=0xFE000EE3, pc=0x200, valid=1 -> taken=1, target=0x1FC.
- BEQ +8: rdata=0x00000463, pc=0x200, valid=1 -> taken=0, target=0x208.
- C.J -2: rdata=0x0000BFFD, pc=0x300, valid=1 -> taken=1, target=0x2FE.
  - Same stimulus with BRANCH_PREDICT_RVC_EN undefined -> taken=0.
- C.BEQZ -2: rdata=0x0000DC7D, pc=0x400 -> taken=1, target=0x3FE.
  - Same word with valid=0 -> taken=0.
- ADDI: rdata=0x00000013, any pc, valid=1 -> taken=0.
- Wrap-around: JAL +8 at pc=0xFFFFFFFC -> target=0x00000004.
